// File: rtl/ddr_if_pkg.sv
// Shared definitions for the DDR request/acknowledge interface, used by the
// burst master and by simple_ddr_ctrl.
package ddr_if_pkg;

  localparam int unsigned DDR_ADDR_WIDTH = 28;
  localparam int unsigned DDR_DATA_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WFETCH = 3'd1,
    REQ    = 3'd2,
    RHOLD  = 3'd3,
    DONE   = 3'd4
  } burst_state_t;

endpackage

// File: rtl/ddr_ack_watchdog.sv
// Counts cycles spent waiting for mem_ack; timeout fires in the
// ACK_TIMEOUT-th enabled cycle after a clear.
module ddr_ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = en && (count == LIMIT);

endmodule

// File: rtl/ddr_burst_master.sv
// Burst initiator for the simple_ddr_ctrl mem_* interface: one single-word
// request per word at incrementing addresses, fed from / drained to streams.
module ddr_burst_master
  import ddr_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DDR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DDR_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  burst_state_t         state, state_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 we_q;
  logic                 accept, advance, load_wdata, capture_rdata, set_err;
  logic                 wd_timeout;
  logic                 last_word;

  assign last_word = (remaining == LEN_WIDTH'(1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WFETCH);

  ddr_ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state != REQ),
    .en     (state == REQ),
    .timeout(wd_timeout)
  );

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    advance       = 1'b0;
    load_wdata    = 1'b0;
    capture_rdata = 1'b0;
    set_err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0)  state_next = DONE;
          else if (cmd_we)    state_next = WFETCH;
          else                state_next = REQ;
        end
      end
      WFETCH: begin
        if (wr_valid) begin
          load_wdata = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // An ack arriving in the timeout cycle still completes the word.
        if (mem_ack) begin
          if (we_q) begin
            advance    = 1'b1;
            state_next = last_word ? DONE : WFETCH;
          end else begin
            capture_rdata = 1'b1;
            state_next    = RHOLD;
          end
        end else if (wd_timeout) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      RHOLD: begin
        if (rd_ready) begin
          advance    = 1'b1;
          state_next = last_word ? DONE : REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state so they are
  // glitch-free toward the controller and the stream sink.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_next;
      mem_req  <= (state_next == REQ);
      mem_we   <= (state_next == REQ) && (accept ? cmd_we : we_q);
      rd_valid <= (state_next == RHOLD);
      done     <= (state_next == DONE);
      if (accept) begin
        mem_addr  <= cmd_addr;
        remaining <= cmd_len;
        we_q      <= cmd_we;
        err       <= 1'b0;
      end
      if (advance) begin
        mem_addr  <= mem_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (set_err)       err       <= 1'b1;
      if (load_wdata)    mem_wdata <= wr_data;
      if (capture_rdata) rd_data   <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ddr_burst_master.sv
// Self-checking bench for ddr_burst_master: randomized bursts against an
// event-level model, plus directed scenarios with literal expectations.
module tb_ddr_burst_master;

  localparam int unsigned AW  = 28;
  localparam int unsigned DW  = 128;
  localparam int unsigned LW  = 16;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_req, mem_ack;
  logic          busy, done, err;

  always #5 clk = ~clk;

  ddr_burst_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_we(cmd_we),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: what the outputs must be in the current cycle
  bit            e_busy, e_req, e_wrr, e_rdv, e_done, e_err;
  logic [AW-1:0] m_base;
  int            m_len, m_done_words;
  bit            m_we;
  logic [DW-1:0] m_wdata;
  int unsigned   req_age;

  // stimulus controls
  bit            pend;
  logic [AW-1:0] p_addr;
  logic [LW-1:0] p_len;
  bit            p_we;
  logic [DW-1:0] wq[$];
  int unsigned   ack_delay, wait_cnt, wr_pct, rd_pct;
  bit            no_ack, ack_noise;
  int            stall_beat, stall_left;

  // observation logs
  int            cyc;
  logic [AW-1:0] req_log[$];
  logic [DW-1:0] wdata_log[$];
  logic [DW-1:0] rd_log[$];
  int            done_cnt, req_cycles, overlap, accept_cyc, done_cyc, prev_done;
  bit            err_at_done;

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {4{4'h0, a}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rst = 1'b0);
    bit acc, wf, ak, rf;
    bit n_busy, n_req, n_wrr, n_rdv, n_done, n_err;
    logic [AW-1:0] cur;
    reset_n   = ~rst;
    cmd_valid = pend & ~rst;
    cmd_addr  = p_addr;
    cmd_len   = p_len;
    cmd_we    = p_we;
    wr_valid  = (wq.size() > 0) && ($urandom_range(99) < wr_pct);
    wr_data   = wr_valid ? wq[0] : rnd_word();
    if (rd_valid && m_done_words == stall_beat && stall_left > 0) begin
      rd_ready = 1'b0;
      stall_left--;
    end else begin
      rd_ready = ($urandom_range(99) < rd_pct);
    end
    if (mem_req) begin
      if (!no_ack && wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_of(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = rnd_word();
        wait_cnt++;
      end
    end else begin
      mem_ack   = ack_noise && ($urandom_range(3) == 0);
      mem_rdata = rnd_word();
      wait_cnt  = 0;
    end

    acc = cmd_valid && !e_busy;
    wf  = wr_valid && e_wrr;
    ak  = mem_ack && e_req;
    rf  = rd_ready && e_rdv;
    n_busy = e_busy; n_req = e_req; n_wrr = e_wrr; n_rdv = e_rdv;
    n_done = 1'b0;   n_err = e_err;
    if (e_done) n_busy = 1'b0;
    if (acc) begin
      pend = 1'b0; n_busy = 1'b1; n_err = 1'b0;
      m_base = p_addr; m_len = int'(p_len); m_we = p_we; m_done_words = 0;
      prev_done = done_cyc; accept_cyc = cyc;
      if (p_len == '0) n_done = 1'b1;
      else if (p_we)   n_wrr  = 1'b1;
      else             n_req  = 1'b1;
    end
    if (wf) begin
      n_wrr = 1'b0; n_req = 1'b1; m_wdata = wr_data;
      void'(wq.pop_front());
    end
    if (ak) begin
      n_req = 1'b0; req_age = 0;
      req_log.push_back(mem_addr);
      if (m_we) begin
        wdata_log.push_back(mem_wdata);
        m_done_words++;
        if (m_done_words == m_len) n_done = 1'b1;
        else                       n_wrr  = 1'b1;
      end else begin
        n_rdv = 1'b1;
      end
    end else if (e_req) begin
      req_age++;
      if (req_age == TMO) begin
        n_req = 1'b0; req_age = 0; n_done = 1'b1; n_err = 1'b1;
      end
    end
    if (rf) begin
      rd_log.push_back(rd_data);
      n_rdv = 1'b0;
      m_done_words++;
      if (m_done_words == m_len) n_done = 1'b1;
      else                       n_req  = 1'b1;
    end
    if (rst) begin
      n_busy = 0; n_req = 0; n_wrr = 0; n_rdv = 0; n_done = 0; n_err = 0;
      req_age = 0; pend = 1'b0; wq.delete(); stall_left = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
    e_busy = n_busy; e_req = n_req; e_wrr = n_wrr; e_rdv = n_rdv;
    e_done = n_done; e_err = n_err;
    if (mem_req) req_cycles++;
    if (mem_req && rd_valid) overlap++;
    if (done) begin
      done_cnt++; done_cyc = cyc; err_at_done = err;
    end

    check("busy", busy, e_busy);
    check("cmd_ready", cmd_ready, !e_busy);
    check("mem_req", mem_req, e_req);
    check("wr_ready", wr_ready, e_wrr);
    check("rd_valid", rd_valid, e_rdv);
    check("done", done, e_done);
    check("err", err, e_err);
    cur = m_base + AW'(m_done_words);
    if (e_req) begin
      check("mem_addr", mem_addr, cur);
      check("mem_we", mem_we, m_we);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_rdv) check("rd_data", rd_data, rdata_of(cur));
    if (rst) begin
      check("rst_mem_addr", mem_addr, '0);
      check("rst_mem_wdata", mem_wdata, '0);
      check("rst_rd_data", rd_data, '0);
      check("rst_mem_we", mem_we, '0);
    end
  endtask

  task automatic submit(input logic [AW-1:0] a, input int len, input bit we, input bit gen);
    pend = 1'b1; p_addr = a; p_len = LW'(len); p_we = we;
    if (we && gen) for (int i = 0; i < len; i++) wq.push_back(rnd_word());
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((pend || e_busy) && n < 3000);
    if (pend || e_busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s_budget: still busy after %0d cycles, required idle", name, n);
      cycle(1'b1);
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); wdata_log.delete(); rd_log.delete();
    done_cnt = 0; req_cycles = 0; overlap = 0; err_at_done = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_we = 1'b0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    pend = 0; p_addr = '0; p_len = '0; p_we = 0;
    e_busy = 0; e_req = 0; e_wrr = 0; e_rdv = 0; e_done = 0; e_err = 0;
    m_base = '0; m_len = 0; m_done_words = 0; m_we = 0; m_wdata = '0; req_age = 0;
    ack_delay = 0; wait_cnt = 0; wr_pct = 100; rd_pct = 100; no_ack = 0; ack_noise = 0;
    stall_beat = -1; stall_left = 0; cyc = 0; accept_cyc = 0; done_cyc = 0; prev_done = 0;
    clear_logs();

    cycle(1'b1);
    cycle(1'b1);
    cycle();

    // write burst, ack two cycles after each request
    clear_logs();
    ack_delay = 2;
    wq.push_back(128'h01); wq.push_back(128'h02); wq.push_back(128'h03);
    submit(28'h000000A, 3, 1'b1, 1'b0);
    wait_idle("write");
    check("wr_n_req", req_log.size(), 3);
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      check("wr_addr", req_log[i], 28'h000000A + 28'(i));
      check("wr_wdata", wdata_log[i], 128'(i + 1));
    end
    check("wr_done_cnt", done_cnt, 1);
    check("wr_err", err_at_done, 0);

    // read burst with a three-cycle sink stall on the second beat
    clear_logs();
    ack_delay = 1; stall_beat = 1; stall_left = 3;
    submit(28'h0000100, 4, 1'b0, 1'b0);
    wait_idle("read");
    check("rd_n_beats", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check("rd_beat", rd_log[i][AW-1:0], 28'h0000100 + 28'(i));
    check("rd_stall_used", stall_left, 0);
    check("rd_req_overlap", overlap, 0);
    stall_beat = -1;

    // address wrap
    clear_logs();
    ack_delay = 0;
    submit(28'hFFFFFFF, 2, 1'b0, 1'b0);
    wait_idle("wrap");
    check("wrap_n_req", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check("wrap_addr0", req_log[0], 28'hFFFFFFF);
      check("wrap_addr1", req_log[1], 28'h0000000);
    end

    // ack timeout, then err cleared by the next accept
    clear_logs();
    no_ack = 1'b1;
    submit(28'h0000055, 2, 1'b0, 1'b0);
    wait_idle("timeout");
    check("tmo_req_cycles", req_cycles, TMO);
    check("tmo_done_cnt", done_cnt, 1);
    check("tmo_err_at_done", err_at_done, 1);
    cycle(); cycle();
    check("tmo_err_sticky", err, 1);
    no_ack = 1'b0;
    clear_logs();
    submit(28'h0000060, 1, 1'b0, 1'b0);
    wait_idle("after_tmo");
    check("tmo_err_cleared", err, 0);
    check("tmo_next_done", done_cnt, 1);

    // no-op command, then a command offered while busy
    clear_logs();
    submit(28'h0000020, 0, 1'b1, 1'b0);
    wait_idle("noop");
    check("noop_req_cycles", req_cycles, 0);
    check("noop_done_cnt", done_cnt, 1);
    check("noop_done_latency", done_cyc, accept_cyc + 1);
    clear_logs();
    ack_noise = 1'b1;
    submit(28'h0000030, 2, 1'b1, 1'b1);
    for (int i = 0; i < 10 && !e_busy; i++) cycle();
    submit(28'h0000040, 1, 1'b0, 1'b0);
    wait_idle("backpressure");
    check("bp_accept_after_done", accept_cyc, prev_done + 1);
    check("bp_done_cnt", done_cnt, 2);

    // reset while a request is outstanding
    clear_logs();
    ack_delay = 3;
    submit(28'h0000200, 4, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !mem_req; i++) cycle();
    check("rst_req_before", mem_req, 1);
    cycle(1'b1);
    check("rst_mem_req_now", mem_req, 0);
    check("rst_busy_now", busy, 0);
    check("rst_cmd_ready_now", cmd_ready, 1);
    cycle();

    // randomized bursts
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      clear_logs();
      ack_delay = $urandom_range(3);
      no_ack    = ($urandom_range(19) == 0);
      ack_noise = $urandom_range(1);
      wr_pct    = $urandom_range(100, 40);
      rd_pct    = $urandom_range(100, 40);
      a = ($urandom_range(3) == 0) ? 28'hFFFFFFF - 28'($urandom_range(3)) : AW'($urandom());
      submit(a, $urandom_range(5), $urandom_range(1), 1'b1);
      wait_idle("random");
    end
    no_ack = 1'b0;
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
